frame_gen_scheduler: RTL
========================

Name: frame_gen_scheduler

Overview:
- Sequences one frame_generator instance: issues start pulses and drives its interrupt code.
- Monitors the generator's XGMII-style output (data plus ctrl) to detect start-of-frame (SOF) and end-of-frame (EOF).
- Inserts a programmable inter-frame gap and counts completed frames.
- Used by verification agents and top-level benches to produce bursts of N frames, or a continuous stream, with fault injection on one selected frame.

Parameters:
- DATA_WIDTH, 64, width of the observed generator data word.
- CTRL_WIDTH, DATA_WIDTH/8, width of the observed generator ctrl word.
- CNT_WIDTH, 16, width of the frame-count, frame-index and number-of-frames fields.
- GAP_WIDTH, 8, width of the inter-frame gap field.
- TIMEOUT_CYCLES, 32, maximum cycles allowed in WAIT_SOF, and separately in WAIT_EOF.
- START_CODE, 8'hFB, byte-0 control code that marks SOF.
- TERMINATE_CODE, 8'hFD, byte-0 control code that marks EOF.

Ports:
- clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_go  in  1  single-cycle pulse; loads configuration and starts a run. Ignored while o_busy=1.
- i_num_frames  in  CNT_WIDTH  frames per run; 0 means continuous.
- i_gap_cycles  in  GAP_WIDTH  idle cycles between EOF detect and the next start.
- i_intr_frame  in  CNT_WIDTH  0-based index of the frame that receives i_intr_code.
- i_intr_code  in  8  interrupt code for the selected frame (for example 8'h02 STOP_DATA).
- i_abort  in  1  pulse; ends the run after the current frame.
- i_gen_tx_data  in  DATA_WIDTH  generator o_tx_data.
- i_gen_tx_ctrl  in  CTRL_WIDTH  generator o_tx_ctrl.
- o_gen_start  out  1  to generator i_start.
- o_gen_interrupt  out  8  to generator i_interrupt.
- o_busy  out  1  high while a run is active.
- o_done  out  1  single-cycle pulse when a run ends.
- o_frame_count  out  CNT_WIDTH  frames completed in the current or last run.
- o_timeout_err  out  1  sticky; set by an SOF or EOF timeout, cleared by i_go or reset.

Behaviour:
- All outputs are registered.
- Reset sets every output to 0, the state to IDLE, all counters to 0 and the configuration registers to 0.
- Reset mid-run abandons the run; no o_done pulse is produced.
- SOF detect: i_gen_tx_ctrl[0]=1 and i_gen_tx_data[7:0]=START_CODE.
- EOF detect: i_gen_tx_ctrl[0]=1 and i_gen_tx_data[7:0]=TERMINATE_CODE.
- Both detects are evaluated on the current-cycle inputs.

States:
- IDLE: o_busy=0.
  - On i_go: latch the four configuration inputs, clear o_frame_count and o_timeout_err, set o_busy=1, then go to LAUNCH.
- LAUNCH: o_gen_start=1 for exactly this one cycle. Clear the timer, then go to WAIT_SOF.
- WAIT_SOF:
  - Timer increments every cycle.
  - On SOF detect, go to WAIT_EOF and clear the timer.
  - If the timer reaches TIMEOUT_CYCLES-1 without SOF: set o_timeout_err, go to DONE.
  - The generator's SOF arrives 2 cycles after the o_gen_start cycle.
- WAIT_EOF:
  - o_gen_interrupt = latched code when o_frame_count == latched intr_frame, else 8'h00.
  - It is driven from the cycle of entry into WAIT_EOF until the cycle EOF is seen.
  - On EOF detect:
    - o_frame_count increments, saturating at all-ones.
    - o_gen_interrupt returns to 0 on the next cycle.
    - Go to DONE if (num_frames≠0 and the new count == num_frames) or an abort is pending.
    - Otherwise go to GAP if gap>0, or to LAUNCH if gap=0.
  - Timeout works as in WAIT_SOF, with a separate limit. On timeout: set o_timeout_err, drive o_gen_interrupt to 0, go to DONE.
- GAP:
  - Counts down from gap_cycles and goes to LAUNCH when the count reaches 1.
  - gap=N gives exactly N cycles between the EOF-detect cycle and the LAUNCH cycle.
- DONE: o_done=1 for one cycle, o_busy drops in the same cycle, then go to IDLE.

Abort:
- In GAP or LAUNCH: go to DONE next cycle, with no new start (from LAUNCH, the start pulse of that cycle has already been issued).
- In WAIT_SOF or WAIT_EOF: set abort-pending; the current frame completes first.
- In IDLE: no effect.
- i_abort and i_go in the same IDLE cycle: i_go wins and the abort is discarded.

Simultaneous events:
- Abort together with EOF detect ends the run after that frame.

Test Plan:
1. i_go with num_frames=3, gap=4, intr_code=0 → exactly 3 single-cycle o_gen_start pulses. Each later LAUNCH follows its EOF detect by 5 cycles. o_frame_count steps 1,2,3. One o_done pulse, then o_busy=0.
2. num_frames=2, gap=0, intr_frame=1, intr_code=8'h02 → o_gen_interrupt=8'h02 only while frame 1 is in WAIT_EOF. Frame 1 data bytes read 8'h00 and frame 0 reads 8'hAA. Final count=2.
3. num_frames=0, gap=2; pulse i_abort during the 5th frame's WAIT_EOF → that frame completes, count=5, o_done pulses, and no 6th start is issued.
4. Generator held in reset while the scheduler runs num_frames=1 → after TIMEOUT_CYCLES in WAIT_SOF, o_timeout_err=1 and o_done pulses. The next i_go clears the error.
5. Assert i_rst for 1 cycle mid-GAP → all outputs 0 the next cycle, no o_done. A fresh i_go restarts with count=0.
6. i_go pulsed while o_busy=1 → ignored; configuration unchanged and the frame count continues uninterrupted.

Source files
------------

// File: rtl/frame_gen_scheduler.sv
// Run controller for one frame_generator: pulses its start, watches its
// XGMII-style output for SOF/EOF, spaces frames by a gap and counts them.
module frame_gen_scheduler #(
    parameter int         DATA_WIDTH     = 64,
    parameter int         CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int         CNT_WIDTH      = 16,
    parameter int         GAP_WIDTH      = 8,
    parameter int         TIMEOUT_CYCLES = 32,
    parameter logic [7:0] START_CODE     = 8'hFB,
    parameter logic [7:0] TERMINATE_CODE = 8'hFD
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_go,
    input  logic [CNT_WIDTH-1:0]  i_num_frames,
    input  logic [GAP_WIDTH-1:0]  i_gap_cycles,
    input  logic [CNT_WIDTH-1:0]  i_intr_frame,
    input  logic [7:0]            i_intr_code,
    input  logic                  i_abort,
    input  logic [DATA_WIDTH-1:0] i_gen_tx_data,
    input  logic [CTRL_WIDTH-1:0] i_gen_tx_ctrl,
    output logic                  o_gen_start,
    output logic [7:0]            o_gen_interrupt,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_frame_count,
    output logic                  o_timeout_err
);
    localparam int                   TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_WIDTH-1:0] TMR_LAST  = TMR_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_SOF,
        S_WAIT_EOF,
        S_GAP,
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] num_frames_reg, num_frames_next;
    logic [CNT_WIDTH-1:0] intr_frame_reg, intr_frame_next;
    logic [GAP_WIDTH-1:0] gap_cfg_reg, gap_cfg_next;
    logic [7:0]           intr_code_reg, intr_code_next;
    logic [GAP_WIDTH-1:0] gap_cnt_reg, gap_cnt_next;
    logic [TMR_WIDTH-1:0] timer_reg, timer_next;
    logic [CNT_WIDTH-1:0] frame_count_reg, frame_count_next;
    logic                 abort_pend_reg, abort_pend_next;
    logic                 timeout_err_reg, timeout_err_next;
    logic                 gen_start_reg, busy_reg, done_reg;
    logic [7:0]           gen_interrupt_reg;

    logic sof_det, eof_det;
    assign sof_det = i_gen_tx_ctrl[0] && (i_gen_tx_data[7:0] == START_CODE);
    assign eof_det = i_gen_tx_ctrl[0] && (i_gen_tx_data[7:0] == TERMINATE_CODE);

    // Only lane 0 carries the start/terminate markers.
    logic unused_lanes;
    assign unused_lanes = ^{i_gen_tx_data[DATA_WIDTH-1:8], i_gen_tx_ctrl[CTRL_WIDTH-1:1]};

    always_comb begin
        state_next       = state_reg;
        num_frames_next  = num_frames_reg;
        intr_frame_next  = intr_frame_reg;
        gap_cfg_next     = gap_cfg_reg;
        intr_code_next   = intr_code_reg;
        gap_cnt_next     = gap_cnt_reg;
        timer_next       = timer_reg;
        frame_count_next = frame_count_reg;
        abort_pend_next  = abort_pend_reg;
        timeout_err_next = timeout_err_reg;

        case (state_reg)
            S_IDLE: begin
                if (i_go) begin
                    num_frames_next  = i_num_frames;
                    intr_frame_next  = i_intr_frame;
                    gap_cfg_next     = i_gap_cycles;
                    intr_code_next   = i_intr_code;
                    frame_count_next = '0;
                    timeout_err_next = 1'b0;
                    abort_pend_next  = 1'b0;
                    state_next       = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                timer_next = '0;
                state_next = i_abort ? S_DONE : S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (i_abort) abort_pend_next = 1'b1;
                if (sof_det) begin
                    timer_next = '0;
                    state_next = S_WAIT_EOF;
                end else if (timer_reg == TMR_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = S_DONE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            S_WAIT_EOF: begin
                if (i_abort) abort_pend_next = 1'b1;
                if (eof_det) begin
                    frame_count_next = (frame_count_reg == '1) ? frame_count_reg
                                                               : frame_count_reg + 1'b1;
                    // An abort arriving together with EOF still ends the run here.
                    if (((num_frames_reg != '0) && (frame_count_next == num_frames_reg))
                            || abort_pend_reg || i_abort) begin
                        state_next = S_DONE;
                    end else if (gap_cfg_reg != '0) begin
                        gap_cnt_next = gap_cfg_reg;
                        state_next   = S_GAP;
                    end else begin
                        state_next = S_LAUNCH;
                    end
                end else if (timer_reg == TMR_LAST) begin
                    timeout_err_next = 1'b1;
                    state_next       = S_DONE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            S_GAP: begin
                if (i_abort) begin
                    state_next = S_DONE;
                end else if (gap_cnt_reg <= GAP_WIDTH'(1)) begin
                    state_next = S_LAUNCH;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_reg         <= S_IDLE;
            num_frames_reg    <= '0;
            intr_frame_reg    <= '0;
            gap_cfg_reg       <= '0;
            intr_code_reg     <= '0;
            gap_cnt_reg       <= '0;
            timer_reg         <= '0;
            frame_count_reg   <= '0;
            abort_pend_reg    <= 1'b0;
            timeout_err_reg   <= 1'b0;
            gen_start_reg     <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            gen_interrupt_reg <= '0;
        end else begin
            state_reg         <= state_next;
            num_frames_reg    <= num_frames_next;
            intr_frame_reg    <= intr_frame_next;
            gap_cfg_reg       <= gap_cfg_next;
            intr_code_reg     <= intr_code_next;
            gap_cnt_reg       <= gap_cnt_next;
            timer_reg         <= timer_next;
            frame_count_reg   <= frame_count_next;
            abort_pend_reg    <= abort_pend_next;
            timeout_err_reg   <= timeout_err_next;
            gen_start_reg     <= (state_next == S_LAUNCH);
            busy_reg          <= (state_next inside {S_LAUNCH, S_WAIT_SOF, S_WAIT_EOF, S_GAP});
            done_reg          <= (state_next == S_DONE);
            gen_interrupt_reg <= ((state_next == S_WAIT_EOF) && (frame_count_next == intr_frame_next))
                                 ? intr_code_next : 8'h00;
        end
    end

    assign o_gen_start     = gen_start_reg;
    assign o_gen_interrupt = gen_interrupt_reg;
    assign o_busy          = busy_reg;
    assign o_done          = done_reg;
    assign o_frame_count   = frame_count_reg;
    assign o_timeout_err   = timeout_err_reg;

endmodule
